// File: rtl/fp_mul_norm_round_if.sv
// Handshake bundle for the normalise/round stage of the binary32 multiplier.
// master = producer of operations and consumer of results; slave = the block.
interface fp_mul_norm_round_if #(
  parameter int EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [47:0]      in_mant;
  logic             in_zero;
  logic             in_inf;
  logic             in_nan;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_ovf;
  logic             out_unf;
  logic             out_inexact;

  // A beat moves on a rising clock edge only when valid && ready on that side;
  // a producer holds its payload stable while valid is high and ready is low.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_ovf, out_unf, out_inexact
  );
endinterface

// File: rtl/fp_mul_norm_round.sv
// Normalise, round-to-nearest-even and pack the 48-bit significand product of a
// binary32 multiply. Two pipeline stages with valid/ready flow control.
module fp_mul_norm_round #(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mul_norm_round_if.slave bus
);

  localparam logic [EXP_W+1:0] EXP_SAT = (EXP_W+2)'(255);

  logic s1_adv;
  logic s2_adv;

  // Stage 1 registers: normalised significand, guard/sticky, adjusted exponent.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [EXP_W:0]   s1_exp_q,   s1_exp_d;
  logic [23:0]      s1_m24_q,   s1_m24_d;
  logic             s1_g_q,     s1_g_d;
  logic             s1_st_q,    s1_st_d;
  logic             s1_zero_q,  s1_zero_d;
  logic             s1_inf_q,   s1_inf_d;
  logic             s1_nan_q,   s1_nan_d;

  // Stage 2 registers drive the outputs directly.
  logic             s2_valid_q,   s2_valid_d;
  logic [31:0]      s2_result_q,  s2_result_d;
  logic             s2_ovf_q,     s2_ovf_d;
  logic             s2_unf_q,     s2_unf_d;
  logic             s2_inexact_q, s2_inexact_d;

  logic             round_up;
  logic [24:0]      rnd_sum;
  logic [22:0]      frac;
  logic [EXP_W+1:0] exp_r;
  logic             exp_ovf;
  logic             exp_unf;
  logic             unused_hidden;

  // A stage may load when it is empty or its contents leave this cycle.
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_m24_d   = s1_m24_q;
    s1_g_d     = s1_g_q;
    s1_st_d    = s1_st_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d = bus.in_sign;
        s1_zero_d = bus.in_zero;
        s1_inf_d  = bus.in_inf;
        s1_nan_d  = bus.in_nan;
        if (bus.in_mant[47]) begin
          s1_m24_d = bus.in_mant[47:24];
          s1_g_d   = bus.in_mant[23];
          s1_st_d  = |bus.in_mant[22:0];
          s1_exp_d = {bus.in_exp[EXP_W-1], bus.in_exp} + (EXP_W+1)'(1);
        end else begin
          s1_m24_d = bus.in_mant[46:23];
          s1_g_d   = bus.in_mant[22];
          s1_st_d  = |bus.in_mant[21:0];
          s1_exp_d = {bus.in_exp[EXP_W-1], bus.in_exp};
        end
      end
    end
  end

  // Round to nearest, ties to even; a carry out of the significand renormalises.
  always_comb begin
    round_up = s1_g_q && (s1_st_q || s1_m24_q[0]);
    rnd_sum  = {1'b0, s1_m24_q} + {24'd0, round_up};
    if (rnd_sum[24]) begin
      frac  = 23'd0;
      exp_r = {s1_exp_q[EXP_W], s1_exp_q} + (EXP_W+2)'(1);
    end else begin
      frac  = rnd_sum[22:0];
      exp_r = {s1_exp_q[EXP_W], s1_exp_q};
    end
    exp_ovf = !exp_r[EXP_W+1] && (exp_r >= EXP_SAT);
    exp_unf = exp_r[EXP_W+1] || (exp_r == '0);
  end

  assign unused_hidden = rnd_sum[23];

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_ovf_d     = s2_ovf_q;
    s2_unf_d     = s2_unf_q;
    s2_inexact_d = s2_inexact_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ovf_d     = 1'b0;
        s2_unf_d     = 1'b0;
        s2_inexact_d = 1'b0;
        if (s1_nan_q) begin
          s2_result_d = QNAN;
        end else if (s1_inf_q) begin
          s2_result_d = {s1_sign_q, 8'hFF, 23'd0};
        end else if (s1_zero_q) begin
          s2_result_d = {s1_sign_q, 31'd0};
        end else if (exp_ovf) begin
          s2_result_d  = {s1_sign_q, 8'hFF, 23'd0};
          s2_ovf_d     = 1'b1;
          s2_inexact_d = 1'b1;
        end else if (exp_unf) begin
          s2_result_d  = {s1_sign_q, 31'd0};
          s2_unf_d     = 1'b1;
          s2_inexact_d = 1'b1;
        end else begin
          s2_result_d  = {s1_sign_q, exp_r[7:0], frac};
          s2_inexact_d = s1_g_q || s1_st_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_m24_q     <= '0;
      s1_g_q       <= 1'b0;
      s1_st_q      <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_nan_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_ovf_q     <= 1'b0;
      s2_unf_q     <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_m24_q     <= s1_m24_d;
      s1_g_q       <= s1_g_d;
      s1_st_q      <= s1_st_d;
      s1_zero_q    <= s1_zero_d;
      s1_inf_q     <= s1_inf_d;
      s1_nan_q     <= s1_nan_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_unf_q     <= s2_unf_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_result  = s2_result_q;
  assign bus.out_ovf     = s2_ovf_q;
  assign bus.out_unf     = s2_unf_q;
  assign bus.out_inexact = s2_inexact_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: vector table, latency, backpressure and
// asynchronous reset sequences, with an in-order result scoreboard.
module tb_fp_mul_norm_round;

  localparam int NV = 18;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic        zero;
    logic        inf;
    logic        nan;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pop_idx;
  bit   stop_toggle;
  vec_t vecs[NV];
  logic [34:0] exp_q[$];

  fp_mul_norm_round_if #(.EXP_W(10)) bus ();

  fp_mul_norm_round #(.EXP_W(10), .QNAN(32'h7FC00000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // driver: present at negedge, hold until accepted on a rising edge
  task automatic send(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = v.sign;
    bus.in_exp   = v.exp;
    bus.in_mant  = v.mant;
    bus.in_zero  = v.zero;
    bus.in_inf   = v.inf;
    bus.in_nan   = v.nan;
    #1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=in_ready_low want=accept");
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back({v.res, v.ovf, v.unf, v.inx});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.out_ready = r;
  endtask

  // scoreboard: every result popped must match the oldest expected entry
  always @(negedge clk) begin
    logic [34:0] got;
    logic [34:0] want;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got = {bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out[%0d] got=%h want=none", pop_idx, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL result[%0d] got=%h want=%h (result,ovf,unf,inexact)", pop_idx, got, want);
        end
      end
      pop_idx++;
    end
  end

  initial begin
    total = 0;
    bad = 0;
    pop_idx = 0;
    stop_toggle = 1'b0;
    //              sign exp      mant                  z  i  n  result        o  u  x
    vecs[0]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'h3F800000, 0, 0, 0};
    vecs[1]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h40100000, 0, 0, 0};
    vecs[2]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F800002, 0, 0, 1};
    vecs[3]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F800000, 0, 0, 1};
    vecs[4]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F800000, 1, 0, 1};
    vecs[5]  = '{1'b1, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h80000000, 0, 1, 1};
    vecs[6]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 0, 1, 1, 32'h7FC00000, 0, 0, 0};
    vecs[7]  = '{1'b1, 10'd127, 48'h4000_0000_0000, 1, 1, 0, 32'hFF800000, 0, 0, 0};
    vecs[8]  = '{1'b1, 10'd127, 48'h4000_0000_0000, 1, 0, 0, 32'h80000000, 0, 0, 0};
    vecs[9]  = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h40000000, 0, 0, 1};
    vecs[10] = '{1'b0, 10'd127, 48'h4000_0000_0001, 0, 0, 0, 32'h3F800000, 0, 0, 1};
    vecs[11] = '{1'b0, 10'd127, 48'h4000_0040_0001, 0, 0, 0, 32'h3F800001, 0, 0, 1};
    vecs[12] = '{1'b0, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0, 32'h00000000, 0, 1, 1};
    vecs[13] = '{1'b0, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h7F800000, 1, 0, 1};
    vecs[14] = '{1'b0, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 32'h7F000000, 0, 0, 0};
    vecs[15] = '{1'b0, 10'd0,   48'h7FFF_FFC0_0000, 0, 0, 0, 32'h00800000, 0, 0, 1};
    vecs[16] = '{1'b1, 10'd127, 48'h4000_0000_0000, 1, 0, 1, 32'h7FC00000, 0, 0, 0};
    vecs[17] = '{1'b1, 10'd127, 48'hFFFF_FF80_0000, 0, 0, 0, 32'hC0800000, 0, 0, 1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp = '0;
    bus.in_mant = '0;
    bus.in_zero = 1'b0;
    bus.in_inf = 1'b0;
    bus.in_nan = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // latency: captured in S1 on the accepting edge, visible at S2 one edge later
    bus.out_ready = 1'b1;
    send(vecs[0]);
    check("lat_edge0_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge1_valid", 32'(bus.out_valid), 32'd1);
    check("lat_edge1_result", bus.out_result, 32'h3F800000);
    repeat (3) @(posedge clk);

    // table pass 1: back-to-back with downstream always ready
    for (int i = 0; i < NV; i++) send(vecs[i]);
    repeat (5) @(posedge clk);

    // table pass 2: downstream ready drops every third cycle
    fork
      begin
        for (int i = 0; i < NV; i++) send(vecs[i]);
        stop_toggle = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!stop_toggle) begin
          @(posedge clk);
          #1;
          bus.out_ready = (cyc % 3) != 0;
          cyc++;
        end
      end
    join
    set_ready(1'b1);
    repeat (5) @(posedge clk);

    // backpressure: two accepts fill the pipe, then stall with stable outputs
    set_ready(1'b0);
    send(vecs[0]);
    send(vecs[1]);
    fork
      begin
        send(vecs[2]);
        send(vecs[7]);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
          check("bp_out_valid", 32'(bus.out_valid), 32'd1);
          check("bp_result_stable", bus.out_result, 32'h3F800000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          #2;
          check("bp_no_gap", 32'(bus.out_valid), 32'd1);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset with two ops in flight
    send(vecs[1]);
    send(vecs[2]);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("arst_out_result", bus.out_result, 32'd0);
    check("arst_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    send(vecs[9]);
    check("arst_lat_edge0_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("arst_lat_edge1_valid", 32'(bus.out_valid), 32'd1);
    check("arst_lat_edge1_result", bus.out_result, 32'h40000000);
    repeat (4) @(posedge clk);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
